// File: rtl/operand_entry.sv
// Calculator front end: synchronises the slide switches and buttons, debounces
// ENTER/CLEAR and sequences two operand captures for the adder stage.

module operand_entry_db #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          db_q;
  logic          db_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], raw};
      db_prev_q <= db_q;
      // Count only while the synchronised level disagrees; any agreement restarts.
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        db_q  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse = db_q & ~db_prev_q;
endmodule

module operand_entry #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] b2,
  output logic             operands_valid,
  output logic [1:0]       state_led
);
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  logic [1:0][WIDTH-1:0] sw_sync_q;
  logic [1:0]            btn_raw;
  logic [1:0]            btn_pulse;
  logic                  enter_pulse;
  logic                  clear_pulse;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] b1_q, b1_d, b2_q, b2_d;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (reset) sw_sync_q <= '0;
    else       sw_sync_q <= {sw_sync_q[0], sw};
  end

  // Index 0 is ENTER, index 1 is CLEAR.
  assign btn_raw = {btn_clear, btn_enter};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    operand_entry_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[g]),
      .pulse (btn_pulse[g])
    );
  end

  assign enter_pulse = btn_pulse[0];
  assign clear_pulse = btn_pulse[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_A;
      b1_q    <= '0;
      b2_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      valid_q <= (state_d == READY);
    end
  end

  // Clear outranks a coincident enter, which is simply dropped.
  always_comb begin
    state_d = state_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    if (clear_pulse) begin
      state_d = LOAD_A;
      b1_d    = '0;
      b2_d    = '0;
    end else if (enter_pulse) begin
      case (state_q)
        LOAD_A: begin
          b1_d    = sw_sync_q[1];
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b2_d    = sw_sync_q[1];
          state_d = READY;
        end
        READY:   state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  assign b1             = b1_q;
  assign b2             = b2_q;
  assign operands_valid = valid_q;
  assign state_led      = state_q;
endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: stimulus queues expected output changes,
// a negedge monitor pops one entry per observed change.

module tb_operand_entry;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] b1, b2;
  logic         operands_valid;
  logic [1:0]   state_led;

  operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .sw             (sw),
    .btn_enter      (btn_enter),
    .btn_clear      (btn_clear),
    .b1             (b1),
    .b2             (b2),
    .operands_valid (operands_valid),
    .state_led      (state_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int v1;
    int v2;
    int vl;
    int cyc;  // -1 when the landing edge is not pinned
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic [10:0] prev_obs;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output bundle is one response.
  always @(negedge clk) begin
    logic [10:0] cur;
    exp_t e;
    cur = {state_led, b1, b2, operands_valid};
    if (mon_en && cur !== prev_obs) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got st=%0d b1=%h b2=%h v=%0d, required no change",
                 cyc, state_led, b1, b2, operands_valid);
      end else begin
        e = sb.pop_front();
        if (state_led !== 2'(e.st) || b1 !== W'(e.v1) || b2 !== W'(e.v2) ||
            operands_valid !== 1'(e.vl) || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_bad++;
          $display("FAIL output_event got st=%0d b1=%h b2=%h v=%0d cyc=%0d, required st=%0d b1=%h b2=%h v=%0d cyc=%0d",
                   state_led, b1, b2, operands_valid, cyc, e.st, e.v1, e.v2, e.vl, e.cyc);
        end
      end
    end
    prev_obs = cur;
  end

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Sets sw, lets it synchronise, then holds the chosen button(s) for 'hold'
  // cycles. If exp_st >= 0 one output change is expected; 'timed' pins it to
  // the edge 7 cycles after the first raw sample of the press.
  task automatic press(input logic [W-1:0] v, input bit en, input bit cl, input int hold,
                       input int exp_st, input int e1, input int e2, input int ev, input bit timed);
    exp_t e;
    sw = v;
    repeat (3) @(posedge clk);
    #1;
    if (exp_st >= 0) begin
      e = '{exp_st, e1, e2, ev, timed ? cyc + 1 + D + 3 : -1};
      sb.push_back(e);
    end
    btn_enter = en;
    btn_clear = cl;
    repeat (hold) @(posedge clk);
    #1;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; sw = '0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_b1", int'(b1), 0);
    check("reset_b2", int'(b2), 0);
    check("reset_valid", int'(operands_valid), 0);
    check("reset_state", int'(state_led), 0);
    mon_en = 1'b1;

    // Two captures with exact latency
    press(4'h5, 1, 0, 12, 1, 5, 'hA * 0, 0, 1);
    press(4'hA, 1, 0, 12, 2, 5, 'hA, 1, 1);

    // READY wrap, then build READY with b1=2 b2=7 and wrap again
    press(4'hF, 1, 0, 12, 0, 5, 'hA, 0, 1);
    press(4'h2, 1, 0, 12, 1, 2, 'hA, 0, 0);
    press(4'h7, 1, 0, 12, 2, 2, 7, 1, 0);
    press(4'h1, 1, 0, 12, 0, 2, 7, 0, 1);
    press(4'h9, 1, 0, 12, 1, 9, 7, 0, 0);

    // Clear back to LOAD_A
    press(4'h0, 0, 1, 12, 0, 0, 0, 0, 1);

    // Bounce: high runs of 1..3 cycles never reach acceptance
    sw = 4'hB;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 btn_enter = 1'b1;
      repeat ((i % 3) + 1) @(posedge clk);
      #1 btn_enter = 1'b0;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bounce_state", int'(state_led), 0);
    check("bounce_b1", int'(b1), 0);

    // Long hold: one transition only
    press(4'h6, 1, 0, 100, 1, 6, 0, 0, 1);
    press(4'h0, 0, 1, 12, 0, 0, 0, 0, 0);
    press(4'h3, 1, 0, 12, 1, 3, 0, 0, 0);

    // Enter and clear debounce together: clear wins
    press(4'hD, 1, 1, 12, 0, 0, 0, 0, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("prio_state", int'(state_led), 0);

    // Reset two cycles into a held press
    press(4'hC, 1, 0, 12, 1, 'hC, 0, 0, 0);
    sw = 4'hE;
    repeat (3) @(posedge clk);
    #1 btn_enter = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '{0, 0, 0, 0, cyc + 1};
    sb.push_back(e);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '{1, 'hE, 0, 0, cyc + 1 + D + 3};
    sb.push_back(e);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 btn_enter = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("final_b1", int'(b1), 'hE);
    check("pending_expectations", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
# operand_entry

- Upstream front end of the calculator datapath: captures two WIDTH-bit operands from board slide switches via a debounced ENTER push button.
- Presents the operands as `b1`/`b2` to the adder stage, plus a valid flag for downstream result/display logic.
- Owns all asynchronous board-input handling: synchronisation, debouncing and edge detection. The adder and later stages see only clean, clock-domain signals.

## Interface

Parameters:
- WIDTH, 4, operand width; matches the adder input width.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level change is accepted (10 ms at 50 MHz). Legal range is 1 and up. Benches use 4.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sw  input  WIDTH  raw slide switches; asynchronous to clk.
- btn_enter  input  1  raw ENTER button; active-high, asynchronous, bouncy.
- btn_clear  input  1  raw CLEAR button; active-high, asynchronous, bouncy.
- b1  output  WIDTH  first operand, to the adder.
- b2  output  WIDTH  second operand, to the adder.
- operands_valid  output  1  high while both operands are captured and stable.
- state_led  output  2  current state for board LEDs: 00 LOAD_A, 01 LOAD_B, 10 READY.

## Operation

- **Synchronisers:** `sw`, `btn_enter` and `btn_clear` each pass through a two-flop synchroniser. All later logic uses only the synchronised values.
- **Debouncer (per button):**
  - Holds a debounced level and a counter.
  - Each cycle the synchronised level differs from the debounced level, the counter increments.
  - Any cycle they match, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised level and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- **Edge detect:** a 0 to 1 transition of a debounced level gives a one-cycle pulse (enter_pulse or clear_pulse). Release transitions give no pulse.
- **FSM states:** LOAD_A (reset state), LOAD_B, READY.
  - LOAD_A + enter_pulse: b1 <= synchronised sw; go to LOAD_B.
  - LOAD_B + enter_pulse: b2 <= synchronised sw; go to READY.
  - READY + enter_pulse: go to LOAD_A. b1 and b2 hold their old values until overwritten.
  - Any state + clear_pulse: b1 <= 0, b2 <= 0, go to LOAD_A.
  - Simultaneous enter_pulse and clear_pulse: clear wins; the enter press is discarded.
- **Outputs:**
  - operands_valid = 1 exactly while in READY; registered, so it changes on the same edge as the state.
  - b1 and b2 change only on capture or clear edges and otherwise hold. The adder can treat them as static.
- **Reset values:** b1 = 0, b2 = 0, operands_valid = 0, state_led = 00. Synchroniser flops, debounced levels, counters and the edge-detect history all clear to 0.
- **Reset mid-operation:** reset discards any partial debounce count and any captured operand. A button still held when reset deasserts counts as a fresh press once it has been stable for DEBOUNCE_CYCLES.

## Timing

- Press latency:
  - Raw button first sampled high at edge 0 and held steady.
  - enter_pulse is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - b1/b2 and the state update at edge DEBOUNCE_CYCLES+3.
- The operand value is the synchronised `sw` in the pulse cycle, i.e. the raw switches as they were 2 cycles earlier.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES cycles, on press or release, produces no pulse and no state change.
- One physical press gives exactly one pulse, however long it is held.
- A second press requires a debounced release first.
- Throughput: at most one FSM transition per debounced press. There is no back-pressure and downstream does not handshake.

## Test plan

- **Reset then two presses:** DEBOUNCE_CYCLES=4, reset; sw=4'h5, press ENTER; sw=4'hA, press ENTER -> b1=5, b2=A, operands_valid=1, state_led=10. Each update lands exactly 7 cycles after the raw press.
- **Bounce rejection:** toggle btn_enter with pulses 1-3 cycles wide for 40 cycles, then settle low -> no pulse, state stays LOAD_A, b1=0.
- **Held button:** hold ENTER for 100 cycles in LOAD_A -> exactly one transition to LOAD_B, b1 captured once.
- **Clear priority:** in LOAD_B with b1=3, make enter and clear debounce on the same cycle -> b1=0, b2=0, state LOAD_A, operands_valid=0.
- **READY wrap:** from READY with b1=2, b2=7, press ENTER -> state LOAD_A, operands_valid drops on the same edge, b1=2 and b2=7 held; next press with sw=9 -> b1=9.
- **Reset mid-debounce:** assert reset 2 cycles into a stable press while ENTER stays held -> all outputs return to reset values; pulse occurs 7 cycles after reset deasserts; b1 = sw.
